dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Multi-cycle sequencer between the core's load/store stage and the synchronous data BRAM.
- Accepts one request at a time and decodes func3/address into a byte-lane mask and lane-aligned write data.
- Drives BRAM enable/write-enables, waits out the BRAM read latency and returns the raw word, byte mask and func3 to the load-formatting stage.
- Flags misaligned, out-of-range and illegal-func3 accesses without touching memory.

Parameters:
- ADDR_WIDTH, 10, word-address width of the data BRAM (1024 words = 4 KiB).
- BRAM_LATENCY, 1, cycles from bram_en to valid bram_rdata; legal values 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  core presents a load/store request.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  FUNC3_WIDTH (3)  RV32I load/store func3.
- req_addr  in  DATA_WIDTH (32)  byte address.
- req_wdata  in  DATA_WIDTH  store data, LSB-justified.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  raw BRAM word (loads); 0 for stores and errors.
- rsp_byte_mask  out  4  lanes accessed; 0 on error.
- rsp_func3  out  FUNC3_WIDTH  func3 of the completed request.
- rsp_err  out  1  request rejected (misaligned, out of range, or illegal func3).
- busy  out  1  state != IDLE.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  per-byte write enable.
- bram_addr  out  ADDR_WIDTH  word address, req_addr[ADDR_WIDTH+1:2].
- bram_wdata  out  DATA_WIDTH  lane-aligned store data.
- bram_rdata  in  DATA_WIDTH  BRAM read data.

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous and active-low.
- Reset values: state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_byte_mask=0, rsp_func3=0, rsp_err=0; bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0; busy=0. req_ready=0 while rst_n=0.
- Reset mid-operation: aborts the transaction; bram_en/bram_we are low from the next edge; no response is issued.
- Handshake: a request is accepted on a clock edge with req_valid & req_ready. req_ready = (state==IDLE) & rst_n. Only one request is outstanding.
- Request fields are registered at accept time. The core may change its inputs afterwards.
- Mask, offset off = req_addr[1:0]:
  - Byte (000/100, sb 000): mask = 1<<off.
  - Half (001/101, sh 001): off=0 → 0011, off=2 → 1100.
  - Word (010): 1111.
- Store data: bram_wdata = req_wdata << (8*off), using byte/half replication-free shifting. Lanes outside the mask are don't-care.
- Error conditions, checked in this order (any one is sufficient):
  - half with off[0]=1;
  - word with off≠0;
  - func3 ∈ {011,110,111};
  - store with func3[2]=1;
  - req_addr[31:ADDR_WIDTH+2] ≠ 0.
- FSM IDLE:
  - On handshake with an error: go to RESP with rsp_err=1, rsp_byte_mask=0, rsp_rdata=0, rsp_func3 captured. No BRAM access.
  - On handshake without an error: go to ACCESS.
- FSM ACCESS (1 cycle):
  - bram_en=1, bram_addr valid, bram_we = store ? mask : 0000.
  - Store: go to RESP with rsp_rdata=0.
  - Load: load lat_cnt=BRAM_LATENCY, go to WAIT.
- FSM WAIT:
  - bram_en=0 and lat_cnt decrements each cycle.
  - On the edge where lat_cnt==1: capture bram_rdata into rsp_rdata and go to RESP.
- FSM RESP:
  - rsp_valid=1; all rsp_* outputs are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE.
  - rsp_valid drops and req_ready rises in the same next cycle.
- Latency (handshake edge in cycle T, rsp_ready tied high):
  - error: rsp_valid in T+1;
  - store: rsp_valid in T+2;
  - load: rsp_valid in T+2+BRAM_LATENCY.
- Throughput: the earliest next accept is the cycle after the response handshake.
- bram_we is nonzero only in ACCESS for a store; BRAM writes happen exactly once per store.
- busy=1 in ACCESS, WAIT and RESP.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x10, then lw @0x10 → bram_we=1111 at word addr 4 in T+1; load rsp_rdata=0xDEADBEEF, mask=1111, rsp_valid at T+3 (BRAM_LATENCY=1).
- Byte/half lanes: sb 0xA5 @0x13 → bram_we=1000, bram_wdata[31:24]=0xA5. sh 0x1234 @0x12 → bram_we=1100, wdata[31:16]=0x1234. lbu @0x13 → mask=1000.
- Errors: lh @0x21, lw @0x22, func3=011, and sw @0x0000_1000 (ADDR_WIDTH=10) → each gives rsp_err=1 in T+1, mask=0, bram_en never asserted.
- Backpressure: load completes with rsp_ready=0 for 5 cycles → rsp_valid/rsp_rdata stay stable, req_ready=0. After rsp_ready=1, the next request is accepted the following cycle.
- Latency param: BRAM_LATENCY=3 with lw @0x0 → rsp_valid at T+5, data is the value sampled 3 cycles after bram_en.
- Reset mid-op: rst_n=0 during WAIT → next cycle bram_en=0, rsp_valid=0, busy=0. After release, a fresh lw completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the core's memory stage and a synchronous data BRAM.
// Decodes func3/address into lane masks, rejects bad accesses, and waits out BRAM read latency.
module dmem_access_ctrl #(
    parameter int ADDR_WIDTH   = 10,
    parameter int BRAM_LATENCY = 1,
    localparam int DATA_WIDTH  = 32,
    localparam int FUNC3_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [FUNC3_WIDTH-1:0] req_func3,
    input  logic [DATA_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic [3:0]             rsp_byte_mask,
    output logic [FUNC3_WIDTH-1:0] rsp_func3,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   bram_en,
    output logic [3:0]             bram_we,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic [DATA_WIDTH-1:0]  bram_wdata,
    input  logic [DATA_WIDTH-1:0]  bram_rdata
);

    localparam int LAT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [DATA_WIDTH-1:0]  wdata_reg;
    logic [3:0]             mask_reg;
    logic [3:0]             rsp_mask_reg;
    logic [FUNC3_WIDTH-1:0] func3_reg;
    logic                   we_reg;
    logic                   err_reg;
    logic [LAT_W-1:0]       lat_cnt_reg;
    logic [DATA_WIDTH-1:0]  rdata_reg;

    logic [1:0]            off;
    logic [3:0]            dec_mask;
    logic                  dec_err;
    logic                  addr_hi_nz;
    logic [DATA_WIDTH-1:0] dec_wdata;
    logic                  accept;

    assign off        = req_addr[1:0];
    assign accept     = req_valid & req_ready;
    assign dec_wdata  = req_wdata << {off, 3'b000};
    assign addr_hi_nz = |(req_addr >> (ADDR_WIDTH + 2));

    // func3[1:0] selects the access size; func3[2] only marks an unsigned load.
    always_comb begin
        dec_mask = 4'b0000;
        case (req_func3[1:0])
            2'b00:   dec_mask = 4'b0001 << off;
            2'b01:   dec_mask = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   dec_mask = 4'b1111;
            default: dec_mask = 4'b0000;
        endcase
    end

    always_comb begin
        dec_err = 1'b0;
        if (req_func3[1:0] == 2'b01 && off[0])
            dec_err = 1'b1;
        if (req_func3[1:0] == 2'b10 && off != 2'b00)
            dec_err = 1'b1;
        if (req_func3 == 3'b011 || req_func3[2:1] == 2'b11)
            dec_err = 1'b1;
        if (req_we && req_func3[2])
            dec_err = 1'b1;
        if (addr_hi_nz)
            dec_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = dec_err ? S_RESP : S_ACCESS;
            S_ACCESS: state_next = we_reg ? S_RESP : S_WAIT;
            S_WAIT:   if (lat_cnt_reg == LAT_W'(1)) state_next = S_RESP;
            S_RESP:   if (rsp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == S_IDLE) & rst_n;
        bram_en   = (state_reg == S_ACCESS);
        bram_we   = (state_reg == S_ACCESS && we_reg) ? mask_reg : 4'b0000;
        rsp_valid = (state_reg == S_RESP);
        busy      = (state_reg != S_IDLE);
    end

    // Request fields are frozen at accept so the core may move on immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            wdata_reg    <= '0;
            mask_reg     <= '0;
            rsp_mask_reg <= '0;
            func3_reg    <= '0;
            we_reg       <= 1'b0;
            err_reg      <= 1'b0;
            lat_cnt_reg  <= '0;
            rdata_reg    <= '0;
        end else begin
            if (accept) begin
                addr_reg     <= req_addr[ADDR_WIDTH+1:2];
                wdata_reg    <= dec_wdata;
                mask_reg     <= dec_mask;
                rsp_mask_reg <= dec_err ? 4'b0000 : dec_mask;
                func3_reg    <= req_func3;
                we_reg       <= req_we;
                err_reg      <= dec_err;
                rdata_reg    <= '0;
            end
            if (state_reg == S_ACCESS && !we_reg)
                lat_cnt_reg <= LAT_W'(BRAM_LATENCY);
            else if (state_reg == S_WAIT)
                lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
            if (state_reg == S_WAIT && lat_cnt_reg == LAT_W'(1))
                rdata_reg <= bram_rdata;
        end
    end

    assign bram_addr     = addr_reg;
    assign bram_wdata    = wdata_reg;
    assign rsp_rdata     = rdata_reg;
    assign rsp_byte_mask = rsp_mask_reg;
    assign rsp_func3     = func3_reg;
    assign rsp_err       = err_reg;

endmodule
